// File: rtl/control_unit_top.sv
// Decode-stage control unit: instruction decode, branch resolve and
// multiplier busy tracking with hazard stall.
module control_unit_top #(
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic [5:0] control_unit_funct,
  input  logic       eq_ne,
  output logic       regwrite_d,
  output logic       regdst_d,
  output logic       alusrc_d,
  output logic       memwrite_d,
  output logic       memtoreg_d,
  output logic       se_ze,
  output logic [3:0] aluctrl_d,
  output logic [1:0] outselect_d,
  output logic       start_mult,
  output logic       mult_sign,
  output logic       output_branch,
  output logic [1:0] pcsrc,
  output logic       stall,
  output logic       mult_busy,
  output logic       illegal_instr
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_ADDU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SUBU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [5:0] CNT_LOAD = 6'(MULT_CYCLES - 1);

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic [3:0] aluctrl;
    logic       memwrite;
    logic       memtoreg;
    logic       se_ze;
    logic [1:0] outsel;
    logic       start;
    logic       sign;
    logic       branch;
    logic [1:0] pcsrc;
  } ctrl_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nx;
  logic [5:0] cnt, cnt_nx;
  logic       ill_q;
  ctrl_t      dec, ctrl;
  logic       bad, mdu;

  logic [3:0] r_alu, i_alu;
  logic       r_ok, i_ok, i_se;

  logic op_r, op_lw, op_sw, op_beq, op_bne, op_j;
  logic f_mult, f_multu, f_mfhi, f_mflo;

  assign op_r    = op_code == 6'b000000;
  assign op_lw   = op_code == 6'b100011;
  assign op_sw   = op_code == 6'b101011;
  assign op_beq  = op_code == 6'b000100;
  assign op_bne  = op_code == 6'b000101;
  assign op_j    = op_code == 6'b000010;
  assign f_mult  = control_unit_funct == 6'b011000;
  assign f_multu = control_unit_funct == 6'b011001;
  assign f_mfhi  = control_unit_funct == 6'b010000;
  assign f_mflo  = control_unit_funct == 6'b010010;

  always_comb begin
    r_alu = ALU_AND;
    r_ok  = 1'b1;
    unique case (control_unit_funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100001: r_alu = ALU_ADDU;
      6'b100010: r_alu = ALU_SUB;
      6'b100011: r_alu = ALU_SUBU;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100110: r_alu = ALU_XOR;
      6'b100111: r_alu = ALU_NOR;
      6'b101010: r_alu = ALU_SLT;
      6'b101011: r_alu = ALU_SLTU;
      default:   r_ok  = 1'b0;
    endcase
  end

  // immediate forms: arithmetic/compare sign-extend, logical zero-extend
  always_comb begin
    i_alu = ALU_AND;
    i_ok  = 1'b1;
    i_se  = 1'b0;
    unique case (op_code)
      6'b001000: begin i_alu = ALU_ADD;  i_se = 1'b1; end
      6'b001001: begin i_alu = ALU_ADDU; i_se = 1'b1; end
      6'b001010: begin i_alu = ALU_SLT;  i_se = 1'b1; end
      6'b001011: begin i_alu = ALU_SLTU; i_se = 1'b1; end
      6'b001100: i_alu = ALU_AND;
      6'b001101: i_alu = ALU_OR;
      6'b001110: i_alu = ALU_XOR;
      default:   i_ok  = 1'b0;
    endcase
  end

  always_comb begin
    dec = '0;
    bad = 1'b0;
    mdu = 1'b0;
    unique case (1'b1)
      op_r: begin
        if (r_ok) begin
          dec.regwrite = 1'b1;
          dec.regdst   = 1'b1;
          dec.aluctrl  = r_alu;
        end else if (f_mult || f_multu) begin
          dec.start = 1'b1;
          dec.sign  = f_mult;
          mdu       = 1'b1;
        end else if (f_mfhi || f_mflo) begin
          dec.regwrite = 1'b1;
          dec.regdst   = 1'b1;
          dec.outsel   = f_mfhi ? 2'b01 : 2'b10;
          mdu          = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      i_ok: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.se_ze    = i_se;
        dec.aluctrl  = i_alu;
      end
      op_lw: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memtoreg = 1'b1;
        dec.se_ze    = 1'b1;
        dec.aluctrl  = ALU_ADD;
      end
      op_sw: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.se_ze    = 1'b1;
        dec.aluctrl  = ALU_ADD;
      end
      op_beq: begin
        dec.branch = eq_ne;
        dec.pcsrc  = {1'b0, eq_ne};
      end
      op_bne: begin
        dec.branch = ~eq_ne;
        dec.pcsrc  = {1'b0, ~eq_ne};
      end
      op_j: begin
        dec.branch = 1'b1;
        dec.pcsrc  = 2'b10;
      end
      default: bad = 1'b1;
    endcase
  end

  // HI/LO users wait for the multiplier; a held MULT cannot retrigger
  assign stall = (state == BUSY) && mdu;
  assign ctrl  = stall ? '0 : dec;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: if (ctrl.start) begin
        state_nx = BUSY;
        cnt_nx   = CNT_LOAD;
      end
      BUSY: if (cnt == 6'd0) state_nx = IDLE;
            else cnt_nx = cnt - 6'd1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (bad) ill_q <= 1'b1;
    end
  end

  assign regwrite_d    = ctrl.regwrite;
  assign regdst_d      = ctrl.regdst;
  assign alusrc_d      = ctrl.alusrc;
  assign aluctrl_d     = ctrl.aluctrl;
  assign memwrite_d    = ctrl.memwrite;
  assign memtoreg_d    = ctrl.memtoreg;
  assign se_ze         = ctrl.se_ze;
  assign outselect_d   = ctrl.outsel;
  assign start_mult    = ctrl.start;
  assign mult_sign     = ctrl.sign;
  assign output_branch = ctrl.branch;
  assign pcsrc         = ctrl.pcsrc;
  assign mult_busy     = state == BUSY;
  assign illegal_instr = ill_q;

endmodule

// File: tb/tb_control_unit_top.sv
// Bench for control_unit_top: directed scenarios then random
// instruction streams against an instruction-level reference model.
module tb_control_unit_top;

  localparam int MC = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op_code = 6'd0;
  logic [5:0] funct = 6'b100000;
  logic       eq_ne = 1'b0;
  logic       regwrite_d, regdst_d, alusrc_d, memwrite_d, memtoreg_d;
  logic       se_ze, start_mult, mult_sign, output_branch;
  logic       stall, mult_busy, illegal_instr;
  logic [3:0] aluctrl_d;
  logic [1:0] outselect_d, pcsrc;
  logic [16:0] vec_obs;

  int  errors = 0;
  int  checks = 0;
  int  busy_left = 0;
  bit  ill = 1'b0;
  logic last_st, last_mb;

  typedef struct {
    logic [16:0] vec;
    bit          bad;
    bit          mdu;
    bit          start;
  } exp_t;

  control_unit_top dut (
    .clk(clk), .reset(reset), .op_code(op_code),
    .control_unit_funct(funct), .eq_ne(eq_ne),
    .regwrite_d(regwrite_d), .regdst_d(regdst_d),
    .alusrc_d(alusrc_d), .memwrite_d(memwrite_d),
    .memtoreg_d(memtoreg_d), .se_ze(se_ze),
    .aluctrl_d(aluctrl_d), .outselect_d(outselect_d),
    .start_mult(start_mult), .mult_sign(mult_sign),
    .output_branch(output_branch), .pcsrc(pcsrc),
    .stall(stall), .mult_busy(mult_busy),
    .illegal_instr(illegal_instr)
  );

  assign vec_obs = {regwrite_d, regdst_d, alusrc_d, aluctrl_d,
                    memwrite_d, memtoreg_d, se_ze, outselect_d,
                    start_mult, mult_sign, output_branch, pcsrc};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] op,
                                 input logic [5:0] fn,
                                 input logic eq);
    exp_t e;
    logic rw, rd, as, mw, mr, se, sm, ms, br;
    logic [3:0] alu;
    logic [1:0] os, pc;
    int a;
    {rw, rd, as, mw, mr, se, sm, ms, br} = '0;
    alu = 4'd0; os = 2'd0; pc = 2'd0;
    e.bad = 1'b0; e.mdu = 1'b0;
    a = -1;
    if (op == 6'd0) begin
      case (fn)
        6'd32: a = 4;  6'd33: a = 5;  6'd34: a = 6;  6'd35: a = 7;
        6'd36: a = 0;  6'd37: a = 1;  6'd38: a = 2;  6'd39: a = 3;
        6'd42: a = 8;  6'd43: a = 9;
        default: a = -1;
      endcase
      if (a >= 0) begin
        rw = 1'b1; rd = 1'b1; alu = a[3:0];
      end else if (fn == 6'd24 || fn == 6'd25) begin
        sm = 1'b1; ms = (fn == 6'd24); e.mdu = 1'b1;
      end else if (fn == 6'd16 || fn == 6'd18) begin
        rw = 1'b1; rd = 1'b1; e.mdu = 1'b1;
        os = (fn == 6'd16) ? 2'b01 : 2'b10;
      end else begin
        e.bad = 1'b1;
      end
    end else if (op >= 6'd8 && op <= 6'd14) begin
      rw = 1'b1; as = 1'b1; se = (op < 6'd12);
      case (op)
        6'd8:    alu = 4'd4;
        6'd9:    alu = 4'd5;
        6'd10:   alu = 4'd8;
        6'd11:   alu = 4'd9;
        6'd12:   alu = 4'd0;
        6'd13:   alu = 4'd1;
        default: alu = 4'd2;
      endcase
    end else begin
      case (op)
        6'd35: begin rw = 1'b1; as = 1'b1; mr = 1'b1; se = 1'b1; alu = 4'd4; end
        6'd43: begin mw = 1'b1; as = 1'b1; se = 1'b1; alu = 4'd4; end
        6'd4:  begin br = eq;  pc = eq ? 2'b01 : 2'b00; end
        6'd5:  begin br = !eq; pc = eq ? 2'b00 : 2'b01; end
        6'd2:  begin br = 1'b1; pc = 2'b10; end
        default: e.bad = 1'b1;
      endcase
    end
    e.start = sm;
    e.vec = {rw, rd, as, alu, mw, mr, se, os, sm, ms, br, pc};
    return e;
  endfunction

  task automatic step(input logic [5:0] op, input logic [5:0] fn,
                      input logic eq, input string tag);
    exp_t e;
    bit stl;
    @(negedge clk);
    op_code = op; funct = fn; eq_ne = eq;
    #1;
    e = model(op, fn, eq);
    stl = (busy_left > 0) && e.mdu;
    chk({tag, ".vec"}, 32'(vec_obs), stl ? 32'd0 : 32'(e.vec));
    chk({tag, ".stall"}, 32'(stall), 32'(stl));
    chk({tag, ".busy"}, 32'(mult_busy), 32'(busy_left > 0));
    chk({tag, ".ill"}, 32'(illegal_instr), 32'(ill));
    last_st = stall;
    last_mb = mult_busy;
    @(posedge clk);
    if (e.start && !stl) busy_left = MC;
    else if (busy_left > 0) busy_left--;
    if (e.bad) ill = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    op_code = 6'd0; funct = 6'b100000;
    #2 reset = 1'b0;
    #1;
    busy_left = 0;
    ill = 1'b0;
    chk({tag, ".rst_busy"}, 32'(mult_busy), 32'd0);
    chk({tag, ".rst_stall"}, 32'(stall), 32'd0);
    chk({tag, ".rst_ill"}, 32'(illegal_instr), 32'd0);
    #1 reset = 1'b1;
  endtask

  localparam logic [5:0] RF [10] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36,
                                     6'd37, 6'd38, 6'd39, 6'd42, 6'd43};

  initial begin
    int n;
    int r;
    logic [5:0] rop, rfn;
    logic req;
    #3;
    chk("init_busy", 32'(mult_busy), 32'd0);
    chk("init_stall", 32'(stall), 32'd0);
    chk("init_ill", 32'(illegal_instr), 32'd0);
    #4 reset = 1'b1;

    step(6'd0, 6'b100000, 1'b0, "add");
    chk("add_lit", 32'(vec_obs), 32'(17'b11001000000000000));

    step(6'b000100, 6'd0, 1'b1, "beq_t");
    step(6'b000100, 6'd0, 1'b0, "beq_n");
    step(6'b000101, 6'd0, 1'b0, "bne_t");
    step(6'b000101, 6'd0, 1'b1, "bne_n");
    step(6'b100011, 6'd0, 1'b0, "lw");
    step(6'b101011, 6'd0, 1'b0, "sw");
    step(6'b000010, 6'd0, 1'b0, "j");

    step(6'd0, 6'b011000, 1'b0, "mult");
    n = 0;
    for (int i = 0; i < MC + 1; i++) begin
      step(6'd0, 6'b010010, 1'b0, "mflo");
      if (last_st) n++;
    end
    chk("mflo_stall_cycles", 32'(n), 32'(MC));
    chk("mflo_release", 32'(last_st), 32'd0);

    step(6'd0, 6'b011001, 1'b0, "multu");
    for (int i = 0; i < 9; i++) step(6'd0, 6'b100001, 1'b0, "addu_busy");
    do_reset("abort");
    step(6'd0, 6'b011000, 1'b0, "mult2");
    n = 0;
    for (int i = 0; i < MC + 8; i++) begin
      step(6'd0, 6'b100000, 1'b0, "add_busy");
      if (last_mb) n++;
    end
    chk("busy_cycles", 32'(n), 32'(MC));

    step(6'b111111, 6'd0, 1'b0, "illegal");
    for (int i = 0; i < 3; i++) step(6'd0, 6'b100000, 1'b0, "add_sticky");
    do_reset("clr_ill");

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      req = 1'($urandom_range(0, 1));
      rop = 6'd0;
      rfn = 6'd0;
      case (r)
        0, 1, 2, 3, 4, 5: rfn = RF[$urandom_range(0, 9)];
        6:  rfn = 6'd24;
        7:  rfn = 6'd25;
        8:  rfn = 6'd16;
        9:  rfn = 6'd18;
        10, 11, 12: rop = 6'(8 + $urandom_range(0, 6));
        13: rop = 6'd35;
        14: rop = 6'd43;
        15: rop = 6'd4;
        16: rop = 6'd5;
        17: rop = 6'd2;
        18: begin
          rop = 6'($urandom_range(0, 63));
          rfn = 6'($urandom_range(0, 63));
        end
        default: rfn = 6'd16;
      endcase
      if (r == 19 && $urandom_range(0, 3) == 0) do_reset("rnd_rst");
      else step(rop, rfn, req, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit_top.md
CONTROL_UNIT_TOP -- requirements
Module: control_unit_TOP

Interface
REQ-001 Parameter MULT_CYCLES, default 32: number of cycles the datapath multiplier stays busy after a start_mult pulse (legal range 2..63).
REQ-002 clk  input  1  single clock domain; all state changes on the rising edge.
REQ-003 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 op_code  input  6  instruction bits [31:26] from the datapath decode stage.
REQ-005 control_unit_funct  input  6  instruction bits [5:0] from the datapath decode stage.
REQ-006 eq_ne  input  1  register-compare result: 1 means rs==rt.
REQ-007 regwrite_d, regdst_d, alusrc_d, memwrite_d, memtoreg_d, se_ze  output  1 each  decode-stage control bits.
REQ-008 aluctrl_d  output  4  ALU operation code.
REQ-009 outselect_d  output  2  result select: 00 ALU, 01 HI, 10 LO.
REQ-010 start_mult, mult_sign  output  1 each  multiplier start pulse and signed-mode select.
REQ-011 output_branch  output  1  branch taken, flushes fetch.
REQ-012 pcsrc  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target.
REQ-013 stall  output  1  freezes fetch and decode stages.
REQ-014 mult_busy  output  1  multiplier FSM is in BUSY.
REQ-015 illegal_instr  output  1  sticky flag for an undecodable instruction.

Function
REQ-016 aluctrl_d encoding: AND 0000, OR 0001, XOR 0010, NOR 0011, ADD 0100, ADDU 0101, SUB 0110, SUBU 0111, SLT 1000, SLTU 1001.
REQ-017 R-type (op 000000) funct decode: ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011.
- Each SHALL drive regwrite_d=1, regdst_d=1, alusrc_d=0, outselect_d=00, and aluctrl_d per REQ-016.
REQ-018 ADD SHALL drive the 17-bit vector {regwrite_d, regdst_d, alusrc_d, aluctrl_d, memwrite_d, memtoreg_d, se_ze, outselect_d, start_mult, mult_sign, output_branch, pcsrc} = 11001000000000000.
REQ-019 I-type ALU ops SHALL drive regwrite_d=1, regdst_d=0, alusrc_d=1:
- ADDI 001000 and ADDIU 001001 (add), SLTI 001010 and SLTIU 001011 (compare): se_ze=1.
- ANDI 001100, ORI 001101, XORI 001110: se_ze=0.
REQ-020 LW 100011 SHALL drive regwrite_d=1, alusrc_d=1, memtoreg_d=1, se_ze=1, aluctrl_d=ADD.
REQ-021 SW 101011 SHALL drive memwrite_d=1, alusrc_d=1, se_ze=1, aluctrl_d=ADD, regwrite_d=0.
REQ-022 Branches SHALL evaluate eq_ne combinationally in the same cycle:
- BEQ 000100 with eq_ne=1, or BNE 000101 with eq_ne=0: output_branch=1, pcsrc=01.
- Otherwise: output_branch=0, pcsrc=00.
REQ-023 J 000010 SHALL drive pcsrc=10, output_branch=1, regwrite_d=0.
REQ-024 MULT (funct 011000) and MULTU (funct 011001) SHALL pulse start_mult for one cycle with mult_sign=1 and 0 respectively, and regwrite_d=0.
REQ-025 MFHI (funct 010000) and MFLO (funct 010010) SHALL drive regwrite_d=1, regdst_d=1, and outselect_d=01 and 10 respectively.
REQ-026 Multiplier FSM has two states, IDLE and BUSY, plus a 6-bit down-counter:
- IDLE to BUSY on an unstalled start_mult, loading the counter with MULT_CYCLES-1.
- In BUSY the counter decrements every cycle; BUSY returns to IDLE on the edge where the counter reaches 0.
- mult_busy is therefore high for exactly MULT_CYCLES cycles.
REQ-027 stall=1 while in BUSY and the decoded instruction is MULT, MULTU, MFHI or MFLO; stall=0 in every other case.
REQ-028 While stall=1, all outputs except stall and mult_busy SHALL be 0 (bubble); the instruction is re-decoded each cycle until stall falls.
REQ-029 An undefined op_code or R-type funct SHALL drive all control outputs to 0 and set illegal_instr on the next rising edge.
- illegal_instr holds at 1 until reset.
REQ-030 All decode outputs are combinational from op_code, control_unit_funct, eq_ne and FSM state; only the FSM, the counter and illegal_instr are registered.

Reset
REQ-031 reset=0 SHALL immediately force FSM=IDLE, counter=0 and illegal_instr=0, independent of clk.
- Consequently mult_busy=0 and stall=0; decode outputs follow their inputs.
REQ-032 Reset asserted mid-multiply SHALL abort BUSY; after release the next MULT starts a full MULT_CYCLES count.

Verification
REQ-033 op=000000, funct=100000 -> 17-bit vector 11001000000000000, stall=0.
REQ-034 BEQ with eq_ne=1 -> output_branch=1, pcsrc=01; same instruction with eq_ne=0 -> output_branch=0, pcsrc=00; BNE gives the inverse.
REQ-035 MULT decoded at cycle N -> start_mult=1 in cycle N only; mult_busy=1 for cycles N+1..N+32.
- MFLO presented at N+1 -> stall=1 and all outputs 0 through N+32; at N+33 stall=0, outselect_d=10, regwrite_d=1.
REQ-036 MULTU issued, reset pulsed low at BUSY cycle 10 -> mult_busy=0 asynchronously; a new MULT after release yields 32 busy cycles.
REQ-037 op=111111 for one cycle -> all control outputs 0 in that cycle; illegal_instr=1 from the next edge and held through later valid ADDs until reset.
REQ-038 LW, then SW, then J -> LW: regwrite/alusrc/memtoreg/se_ze=1; SW: memwrite=1, regwrite=0; J: pcsrc=10.
